// File: rtl/mmio_timer_if.sv
// Data-memory port of the single-cycle core, as seen by a memory-mapped peripheral.
// The CPU side drives the store strobe/address/data; the peripheral returns load data and its hit.
interface mmio_timer_if;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic [31:0] memreaddata;
   logic        sel;

   modport master (output memwrite, memaddr, memwritedata, input memreaddata, sel);
   modport slave  (input memwrite, memaddr, memwritedata, output memreaddata, sel);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare-match interrupt on the core's data-memory port.
// Loads are combinational; stores commit on the rising edge like the data memory.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   mmio_timer_if.slave bus,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL = 3'd0;
   localparam logic [2:0] OFF_PRE  = 3'd1;
   localparam logic [2:0] OFF_CMP  = 3'd2;
   localparam logic [2:0] OFF_CNT  = 3'd3;
   localparam logic [2:0] OFF_STAT = 3'd4;

   logic [2:0]            ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pcnt;
   logic [31:0]           compare;
   logic [31:0]           count;
   logic [1:0]            status;

   logic                  hit;
   logic [2:0]            off;
   logic                  we;
   logic                  wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_stat;
   logic                  en, auto_rl, ie;
   logic                  tick;
   logic [31:0]           count_nx;
   logic                  match_set, wrap_set;
   logic [1:0]            w1c;
   logic [31:0]           rd;

   // Byte lanes and bits outside the register widths are intentionally not decoded.
   logic unused_bits;
   assign unused_bits = ^{bus.memaddr[1:0], bus.memwritedata[31:3]};

   assign hit = (bus.memaddr[31:5] == BASE_ADDR[31:5]);
   assign off = bus.memaddr[4:2];
   assign we  = bus.memwrite & hit;

   assign wr_ctrl = we && (off == OFF_CTRL);
   assign wr_pre  = we && (off == OFF_PRE);
   assign wr_cmp  = we && (off == OFF_CMP);
   assign wr_cnt  = we && (off == OFF_CNT);
   assign wr_stat = we && (off == OFF_STAT);

   assign en      = ctrl[0];
   assign auto_rl = ctrl[1];
   assign ie      = ctrl[2];

   assign tick = en && (pcnt == prescale);

   // A software COUNT load on a tick edge suppresses that tick's MATCH/WRAP.
   always_comb begin
      count_nx  = count;
      match_set = 1'b0;
      wrap_set  = 1'b0;
      if (wr_cnt) begin
         count_nx = bus.memwritedata;
      end else if (tick) begin
         if (count == compare) begin
            match_set = 1'b1;
            if (auto_rl) begin
               count_nx = '0;
            end else begin
               count_nx = count + 32'd1;
               wrap_set = &count;
            end
         end else begin
            count_nx = count + 32'd1;
            wrap_set = &count;
         end
      end
   end

   assign w1c = wr_stat ? bus.memwritedata[1:0] : 2'b00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl     <= '0;
         prescale <= '0;
         compare  <= '0;
         count    <= '0;
         status   <= '0;
         pcnt     <= '0;
      end else begin
         if (wr_ctrl) ctrl     <= bus.memwritedata[2:0];
         if (wr_pre)  prescale <= bus.memwritedata[PRESCALE_W-1:0];
         if (wr_cmp)  compare  <= bus.memwritedata;
         count  <= count_nx;
         // Hardware set beats a same-edge W1C.
         status <= (status & ~w1c) | {wrap_set, match_set};
         if (!en || wr_ctrl || wr_pre || tick)
            pcnt <= '0;
         else
            pcnt <= pcnt + PRESCALE_W'(1);
      end
   end

   always_comb begin
      rd = '0;
      if (hit) begin
         case (off)
            OFF_CTRL: rd[2:0]            = ctrl;
            OFF_PRE:  rd[PRESCALE_W-1:0] = prescale;
            OFF_CMP:  rd                 = compare;
            OFF_CNT:  rd                 = count;
            OFF_STAT: rd[1:0]            = status;
            default:  rd                 = '0;
         endcase
      end
   end

   assign bus.memreaddata = rd;
   assign bus.sel         = hit;
   assign irq             = status[0] & ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: table-driven register access plus hand-timed counting sequences.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] R_CTRL = 32'h00, R_PRE = 32'h04, R_CMP = 32'h08,
                          R_CNT = 32'h0C, R_STAT = 32'h10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   n_checks = 0;
  int   n_fail = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t tbl_rst[9];
  vec_t tbl_rw[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.memaddr      = a;
    bus.memwritedata = d;
    bus.memwrite     = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite     = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.memwrite = 1'b0;
    bus.memaddr  = a;
    #1;
    d = bus.memreaddata;
  endtask

  task automatic check_reg(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(BASE + off, d);
    check(name, d, exp);
  endtask

  task automatic run_table(input string tag, input vec_t t);
    logic [31:0] d;
    if (t.wr) bus_write(t.addr, t.wdata);
    bus_read(t.addr, d);
    check({tag, "_rd"}, d, t.exp_rd);
    check({tag, "_sel"}, {31'b0, bus.sel}, {31'b0, t.exp_sel});
  endtask

  initial begin
    bus.memwrite = 1'b0;
    bus.memaddr = BASE + 32'h20;
    bus.memwritedata = '0;

    for (int i = 0; i < 8; i++)
      tbl_rst[i] = '{1'b0, BASE + 32'(i * 4), 32'h0, 32'h0, 1'b1};
    tbl_rst[8] = '{1'b0, BASE + 32'h20, 32'h0, 32'h0, 1'b0};

    tbl_rw[0] = '{1'b1, BASE + R_CTRL, 32'hFFFF_FFFE, 32'h0000_0006, 1'b1};
    tbl_rw[1] = '{1'b1, BASE + R_PRE,  32'hABCD_1234, 32'h0000_1234, 1'b1};
    tbl_rw[2] = '{1'b1, BASE + R_CMP,  32'h1234_5678, 32'h1234_5678, 1'b1};
    tbl_rw[3] = '{1'b1, BASE + R_CNT,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    tbl_rw[4] = '{1'b1, BASE + 32'h14, 32'hDEAD_BEEF, 32'h0,         1'b1};
    tbl_rw[5] = '{1'b0, BASE + 32'h0B, 32'h0,         32'h1234_5678, 1'b1};
    tbl_rw[6] = '{1'b1, BASE + R_STAT, 32'h0000_0003, 32'h0,         1'b1};
    tbl_rw[7] = '{1'b1, BASE + R_CTRL, 32'h0,         32'h0,         1'b1};
    tbl_rw[8] = '{1'b0, BASE + R_CNT,  32'h0,         32'hCAFE_F00D, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) run_table($sformatf("rst%0d", i), tbl_rst[i]);
    check("irq_after_reset", {31'b0, irq}, 32'h0);

    // Register write/readback with EN=0
    for (int i = 0; i < 9; i++) run_table($sformatf("rw%0d", i), tbl_rw[i]);

    // Periodic match: ticks every 4 clocks, match on the 5th tick
    bus_write(BASE + R_PRE, 32'd3);
    bus_write(BASE + R_CMP, 32'd4);
    bus_write(BASE + R_CNT, 32'd0);
    bus_write(BASE + R_CTRL, 32'h7);
    repeat (19) @(posedge clk);
    #1;
    check_reg("per_stat_e19", R_STAT, 32'h0);
    check("per_irq_e19", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_reg("per_stat_e20", R_STAT, 32'h1);
    check("per_irq_e20", {31'b0, irq}, 32'h1);
    check_reg("per_cnt_e20", R_CNT, 32'h0);

    // W1C on a non-match edge
    bus_write(BASE + R_STAT, 32'h1);
    check_reg("w1c_stat", R_STAT, 32'h0);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    repeat (18) @(posedge clk);
    #1;
    check_reg("per_stat_e39", R_STAT, 32'h0);
    @(posedge clk);
    #1;
    check_reg("per_stat_e40", R_STAT, 32'h1);
    check("per_irq_e40", {31'b0, irq}, 32'h1);

    // W1C colliding with the match at edge 60
    bus_write(BASE + R_STAT, 32'h1);
    repeat (18) @(posedge clk);
    #1;
    check_reg("coll_pre_stat", R_STAT, 32'h0);
    bus_write(BASE + R_STAT, 32'h1);
    check_reg("coll_stat", R_STAT, 32'h1);
    check_reg("coll_cnt", R_CNT, 32'h0);
    check("coll_irq", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-run
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check_reg("mid_rst_ctrl", R_CTRL, 32'h0);
    check_reg("mid_rst_pre", R_PRE, 32'h0);
    check_reg("mid_rst_cmp", R_CMP, 32'h0);
    check_reg("mid_rst_cnt", R_CNT, 32'h0);
    check_reg("mid_rst_stat", R_STAT, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_reg("post_rst_cnt", R_CNT, 32'h0);
    check_reg("post_rst_stat", R_STAT, 32'h0);

    // COUNT write on a match tick: written value wins, no MATCH
    bus_write(BASE + R_PRE, 32'd0);
    bus_write(BASE + R_CMP, 32'd5);
    bus_write(BASE + R_CNT, 32'd5);
    bus_write(BASE + R_CTRL, 32'h1);
    bus_write(BASE + R_CNT, 32'h100);
    check_reg("cntwr_cnt", R_CNT, 32'h100);
    check_reg("cntwr_stat", R_STAT, 32'h0);
    bus_write(BASE + R_CTRL, 32'h0);

    // Wrap
    bus_write(BASE + R_CNT, 32'hFFFF_FFFF);
    bus_write(BASE + R_STAT, 32'h3);
    bus_write(BASE + R_CTRL, 32'h1);
    check_reg("wrap_cnt_e0", R_CNT, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check_reg("wrap_cnt_e1", R_CNT, 32'h0);
    check_reg("wrap_stat_e1", R_STAT, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    check_reg("wrap_cnt_e6", R_CNT, 32'h5);
    check_reg("wrap_stat_e6", R_STAT, 32'h2);
    @(posedge clk);
    #1;
    check_reg("wrap_stat_e7", R_STAT, 32'h3);
    check_reg("wrap_cnt_e7", R_CNT, 32'h6);
    check("wrap_irq_ie0", {31'b0, irq}, 32'h0);

    // Decode isolation
    bus_write(BASE + R_CTRL, 32'h0);
    bus_write(BASE + R_STAT, 32'h3);
    bus_write(BASE + R_CNT, 32'h55);
    bus.memaddr = BASE + 32'h20;
    bus.memwritedata = 32'hDEAD_BEEF;
    bus.memwrite = 1'b1;
    #1;
    check("iso_sel_20", {31'b0, bus.sel}, 32'h0);
    check("iso_rd_20", bus.memreaddata, 32'h0);
    @(posedge clk);
    #1;
    bus.memaddr = BASE + 32'h14;
    #1;
    check("iso_sel_14", {31'b0, bus.sel}, 32'h1);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    check_reg("iso_ctrl", R_CTRL, 32'h0);
    check_reg("iso_pre", R_PRE, 32'h0);
    check_reg("iso_cmp", R_CMP, 32'h5);
    check_reg("iso_cnt", R_CNT, 32'h55);
    check_reg("iso_stat", R_STAT, 32'h0);
    check_reg("iso_14", 32'h14, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
